hazard_controller: RTL and testbench

Pipeline sequencing controller sitting beside the instruction-decode stage of the 32-bit ARM pipeline. Each cycle it decides whether the instruction in ID may advance, must be replaced by a bubble (RAW hazard), must be squashed (taken branch in EXE), or whether the whole pipeline must freeze (memory stage busy). It also keeps saturating performance counters and a sticky memory-timeout flag for debug.

---
 rtl/hazard_controller_if.sv | 43 ++++
 rtl/hazard_controller.sv | 101 ++++++++++
 tb/tb_hazard_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Decode-side hazard/sequencing bus: pipeline status in, stage control and debug counters out.
interface hazard_controller_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   valid_ID;
  logic [3:0]             src1_HZRD;
  logic [3:0]             src2_HZRD;
  logic                   two_src_HZRD;
  logic                   move_HZRD;
  logic [3:0]             dest_EXE;
  logic                   WB_EN_EXE;
  logic                   MEM_R_EN_EXE;
  logic [3:0]             dest_MEM;
  logic                   WB_EN_MEM;
  logic                   B_EXE;
  logic                   mem_busy;
  logic                   fwd_en;
  logic                   clr_cnt;
  logic                   hazard;
  logic                   freeze_IF;
  logic                   flush_IF;
  logic                   freeze_all;
  logic [STALL_CNT_W-1:0] stall_count;
  logic [STALL_CNT_W-1:0] flush_count;
  logic [STALL_CNT_W-1:0] wait_count;
  logic                   mem_timeout;

  modport master (
    output valid_ID, src1_HZRD, src2_HZRD, two_src_HZRD, move_HZRD,
           dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           B_EXE, mem_busy, fwd_en, clr_cnt,
    input  hazard, freeze_IF, flush_IF, freeze_all,
           stall_count, flush_count, wait_count, mem_timeout
  );

  modport slave (
    input  valid_ID, src1_HZRD, src2_HZRD, two_src_HZRD, move_HZRD,
           dest_EXE, WB_EN_EXE, MEM_R_EN_EXE, dest_MEM, WB_EN_MEM,
           B_EXE, mem_busy, fwd_en, clr_cnt,
    output hazard, freeze_IF, flush_IF, freeze_all,
           stall_count, flush_count, wait_count, mem_timeout
  );
endinterface

// File: rtl/hazard_controller.sv
// ID-stage sequencing: combinational bubble/flush/freeze decisions by priority,
// plus saturating perf counters and a sticky memory-timeout watchdog.
module hazard_controller #(
  parameter int STALL_CNT_W = 16,
  parameter int TIMEOUT     = 1023
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave bus
);
  localparam int              MR_W    = $clog2(TIMEOUT + 1);
  localparam logic [MR_W-1:0] RUN_MAX = MR_W'(TIMEOUT);

  typedef enum logic {RUN, WAIT} state_t;

  state_t                 state;
  logic [MR_W-1:0]        mem_run, run_nxt;
  logic                   match_exe, match_mem, raw;
  logic                   hazard, freeze_IF, flush_IF, freeze_all;
  logic [STALL_CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic                   timeout_q;

  assign match_exe = bus.WB_EN_EXE &
                     ((~bus.move_HZRD & (bus.src1_HZRD == bus.dest_EXE)) |
                      (bus.two_src_HZRD & (bus.src2_HZRD == bus.dest_EXE)));
  assign match_mem = bus.WB_EN_MEM &
                     ((~bus.move_HZRD & (bus.src1_HZRD == bus.dest_MEM)) |
                      (bus.two_src_HZRD & (bus.src2_HZRD == bus.dest_MEM)));
  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw = bus.valid_ID &
               (bus.fwd_en ? (match_exe & bus.MEM_R_EN_EXE) : (match_exe | match_mem));

  always_comb begin
    hazard     = 1'b0;
    freeze_IF  = 1'b0;
    flush_IF   = 1'b0;
    freeze_all = 1'b0;
    if (bus.mem_busy) begin
      freeze_all = 1'b1;
    end else if (bus.B_EXE) begin
      flush_IF = 1'b1;
      hazard   = 1'b1;
    end else if (raw) begin
      hazard    = 1'b1;
      freeze_IF = 1'b1;
    end
  end

  assign bus.hazard     = hazard;
  assign bus.freeze_IF  = freeze_IF;
  assign bus.flush_IF   = flush_IF;
  assign bus.freeze_all = freeze_all;

  // Next busy-run length, so the flag rises on the edge the run reaches TIMEOUT.
  always_comb begin
    run_nxt = '0;
    if (bus.mem_busy) begin
      if (state == RUN)          run_nxt = MR_W'(1);
      else if (mem_run == RUN_MAX) run_nxt = mem_run;
      else                       run_nxt = mem_run + MR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      mem_run   <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN:     if (bus.mem_busy) state <= WAIT;
        WAIT:    if (!bus.mem_busy) state <= RUN;
        default: state <= RUN;
      endcase
      mem_run <= run_nxt;
      if (bus.clr_cnt)                              timeout_q <= 1'b0;
      else if (bus.mem_busy && run_nxt == RUN_MAX)  timeout_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else if (bus.clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (freeze_IF  && !(&stall_cnt)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (flush_IF   && !(&flush_cnt)) flush_cnt <= flush_cnt + STALL_CNT_W'(1);
      if (freeze_all && !(&wait_cnt))  wait_cnt  <= wait_cnt  + STALL_CNT_W'(1);
    end
  end

  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;
  assign bus.wait_count  = wait_cnt;
  assign bus.mem_timeout = timeout_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed vector table, corner sequences and
// randomized traffic against a behavioural model (STALL_CNT_W=4, TIMEOUT=7).
module tb_hazard_controller;
  localparam int W    = 4;
  localparam int TO   = 7;
  localparam int CMAX = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  hazard_controller_if #(.STALL_CNT_W(W)) bus ();
  hazard_controller #(.STALL_CNT_W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    int valid, s1, s2, two, mov, dexe, weexe, ld, dmem, wemem, b, busy, fwd;
    int e_haz, e_fif, e_flush, e_frz;
  } vec_t;

  vec_t tbl[11];

  // behavioural model state
  int m_stall, m_flush, m_wait, m_run;
  bit m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic bit dep(input logic [3:0] d, input logic we);
    bit r1 = !bus.move_HZRD && bus.src1_HZRD == d;
    bit r2 = bus.two_src_HZRD && bus.src2_HZRD == d;
    return we && (r1 || r2);
  endfunction

  // returns {hazard, freeze_IF, flush_IF, freeze_all}
  function automatic logic [3:0] ref_ctl();
    bit e = dep(bus.dest_EXE, bus.WB_EN_EXE);
    bit m = dep(bus.dest_MEM, bus.WB_EN_MEM);
    bit raw = bus.valid_ID && (bus.fwd_en ? (e && bus.MEM_R_EN_EXE) : (e || m));
    if (bus.mem_busy) return 4'b0001;
    if (bus.B_EXE)    return 4'b1010;
    if (raw)          return 4'b1100;
    return 4'b0000;
  endfunction

  task automatic model_reset();
    m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0; m_to = 0;
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_update();
    logic [3:0] c = ref_ctl();
    m_run = bus.mem_busy ? m_run + 1 : 0;
    if (bus.clr_cnt) begin
      m_stall = 0; m_flush = 0; m_wait = 0; m_to = 0;
    end else begin
      if (c[0])      m_wait  = sat(m_wait);
      else if (c[1]) m_flush = sat(m_flush);
      else if (c[2]) m_stall = sat(m_stall);
      if (bus.mem_busy && m_run >= TO) m_to = 1;
    end
  endtask

  // One clock: compare everything at negedge, advance model, return 1 after posedge.
  task automatic cycle();
    logic [3:0] c;
    @(negedge clk);
    c = ref_ctl();
    chk("hazard",      bus.hazard,      c[3]);
    chk("freeze_IF",   bus.freeze_IF,   c[2]);
    chk("flush_IF",    bus.flush_IF,    c[1]);
    chk("freeze_all",  bus.freeze_all,  c[0]);
    chk("stall_count", bus.stall_count, m_stall);
    chk("flush_count", bus.flush_count, m_flush);
    chk("wait_count",  bus.wait_count,  m_wait);
    chk("mem_timeout", bus.mem_timeout, m_to);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    bus.valid_ID     = 1'(v.valid);
    bus.src1_HZRD    = 4'(v.s1);
    bus.src2_HZRD    = 4'(v.s2);
    bus.two_src_HZRD = 1'(v.two);
    bus.move_HZRD    = 1'(v.mov);
    bus.dest_EXE     = 4'(v.dexe);
    bus.WB_EN_EXE    = 1'(v.weexe);
    bus.MEM_R_EN_EXE = 1'(v.ld);
    bus.dest_MEM     = 4'(v.dmem);
    bus.WB_EN_MEM    = 1'(v.wemem);
    bus.B_EXE        = 1'(v.b);
    bus.mem_busy     = 1'(v.busy);
    bus.fwd_en       = 1'(v.fwd);
    bus.clr_cnt      = 1'b0;
  endtask

  task automatic clr_pulse();
    bus.clr_cnt = 1'b1;
    cycle();
    bus.clr_cnt = 1'b0;
  endtask

  initial begin
    vec_t idle, lu;
    idle = '{0,0,0,0,0, 0,0,0, 0,0, 0,0,1, 0,0,0,0};
    lu   = '{1,3,0,0,0, 3,1,1, 0,0, 0,0,1, 1,1,0,0};
    tbl[0]  = idle;
    tbl[1]  = lu;                                         // load-use stall
    tbl[2]  = '{1,3,0,0,0, 3,1,0, 0,0, 0,0,1, 0,0,0,0};   // forwarded ALU result
    tbl[3]  = '{1,0,5,1,0, 9,0,0, 5,1, 0,0,0, 1,1,0,0};   // MEM match on src2
    tbl[4]  = '{1,0,5,0,0, 9,0,0, 5,1, 0,0,0, 0,0,0,0};   // src2 not read
    tbl[5]  = '{1,5,0,0,1, 9,0,0, 5,1, 0,0,0, 0,0,0,0};   // MOV ignores src1
    tbl[6]  = '{1,3,0,0,0, 3,1,1, 0,0, 1,0,1, 1,0,1,0};   // flush beats raw
    tbl[7]  = '{0,3,0,0,0, 3,1,1, 0,0, 0,0,1, 0,0,0,0};   // bubble in ID
    tbl[8]  = '{1,3,0,0,0, 3,1,1, 0,0, 1,1,1, 0,0,0,1};   // freeze beats all
    tbl[9]  = '{1,7,0,0,0, 7,1,0, 2,1, 0,0,0, 1,1,0,0};   // no fwd, EXE match
    tbl[10] = '{1,2,0,0,0, 7,1,0, 2,1, 0,0,1, 0,0,0,0};   // fwd covers MEM match

    apply(idle);
    rst = 1'b1;
    model_reset();
    #3;
    chk("rst_stall",   bus.stall_count, 0);
    chk("rst_flush",   bus.flush_count, 0);
    chk("rst_wait",    bus.wait_count,  0);
    chk("rst_timeout", bus.mem_timeout, 0);
    chk("rst_ctl", {bus.hazard, bus.freeze_IF, bus.flush_IF, bus.freeze_all}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // directed table
    for (int i = 0; i < 11; i++) begin
      apply(tbl[i]);
      #1;
      chk($sformatf("tbl%0d_ctl", i),
          {bus.hazard, bus.freeze_IF, bus.flush_IF, bus.freeze_all},
          {1'(tbl[i].e_haz), 1'(tbl[i].e_fif), 1'(tbl[i].e_flush), 1'(tbl[i].e_frz)});
      cycle();
    end

    // freeze holds a branch for 4 cycles, flush in cycle 5
    apply(idle);
    clr_pulse();
    chk("clr_flush", bus.flush_count, 0);
    apply(lu);
    bus.B_EXE = 1'b1;
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("frz_br_flush", bus.flush_IF, 0);
      chk("frz_br_frz",   bus.freeze_all, 1);
      cycle();
    end
    bus.mem_busy = 1'b0;
    #1;
    chk("br_after_frz", bus.flush_IF, 1);
    cycle();
    chk("wait_4",  bus.wait_count, 4);
    chk("flush_1", bus.flush_count, 1);
    chk("stall_0", bus.stall_count, 0);

    // watchdog: busy for 10 cycles, flag from edge 7 and sticky
    apply(idle);
    bus.mem_busy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cycle();
      chk($sformatf("to_edge%0d", i), bus.mem_timeout, (i >= TO) ? 1 : 0);
    end
    bus.mem_busy = 1'b0;
    cycle();
    cycle();
    chk("to_sticky", bus.mem_timeout, 1);
    clr_pulse();
    chk("clr_to",   bus.mem_timeout, 0);
    chk("clr_wait", bus.wait_count, 0);

    // saturation of stall_count
    apply(lu);
    for (int i = 0; i < 20; i++) cycle();
    chk("stall_sat", bus.stall_count, CMAX);

    // async reset mid-WAIT, then re-enter WAIT with a fresh run
    apply(idle);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    rst = 1'b1;
    #1;
    chk("arst_wait",  bus.wait_count,  0);
    chk("arst_stall", bus.stall_count, 0);
    model_reset();
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      chk($sformatf("rerun_to%0d", i), bus.mem_timeout, (i >= TO) ? 1 : 0);
    end
    bus.mem_busy = 1'b0;
    clr_pulse();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) bus.fwd_en = 1'($urandom_range(0, 1));
      bus.valid_ID     = 1'($urandom_range(0, 3) != 0);
      bus.src1_HZRD    = 4'($urandom_range(0, 3));
      bus.src2_HZRD    = 4'($urandom_range(0, 3));
      bus.dest_EXE     = 4'($urandom_range(0, 3));
      bus.dest_MEM     = 4'($urandom_range(0, 3));
      bus.two_src_HZRD = 1'($urandom_range(0, 1));
      bus.move_HZRD    = 1'($urandom_range(0, 4) == 0);
      bus.WB_EN_EXE    = 1'($urandom_range(0, 1));
      bus.WB_EN_MEM    = 1'($urandom_range(0, 1));
      bus.MEM_R_EN_EXE = 1'($urandom_range(0, 1));
      bus.B_EXE        = 1'($urandom_range(0, 5) == 0);
      bus.mem_busy     = bus.mem_busy ? 1'($urandom_range(0, 9) != 0)
                                      : 1'($urandom_range(0, 9) == 0);
      bus.clr_cnt      = 1'($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
